// File: rtl/vdp_palette_port.sv
// CPU palette write port: V9938-style pointer/data byte pairs are queued in a
// small FIFO and replayed into PaletteRAM, optionally only during blanking.
module vdp_palette_port #(
  parameter int FIFO_DEPTH = 8,
  parameter bit DEFER      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_wr,
  input  logic       cpu_port,
  input  logic [7:0] cpu_din,
  output logic       cpu_ready,
  input  logic       blank,
  output logic       pwrite_enable,
  output logic [5:0] pwaddr,
  output logic [7:0] pin,
  output logic [3:0] ptr,
  output logic       overflow
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  typedef enum logic {
    PH_RB = 1'b0,
    PH_G  = 1'b1
  } phase_e;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } entry_t;

  entry_t      fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic [AW:0] count;
  logic        full;
  logic        empty;

  phase_e      phase_q;
  logic [3:0]  ptr_q;
  logic        overflow_q;
  logic        pwrite_enable_q;
  logic [5:0]  pwaddr_q;
  logic [7:0]  pin_q;

  logic        ptr_wr;
  logic        data_wr;
  logic        push;
  logic        pop;
  entry_t      push_entry;
  entry_t      pop_entry;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_W);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Ready looks only at registered occupancy: a pop in the same cycle does not
  // free a slot for the CPU until the following cycle.
  assign cpu_ready = rst & ~full;

  assign ptr_wr    = cpu_wr & ~cpu_port;
  assign data_wr   = cpu_wr & cpu_port;
  assign push      = data_wr & cpu_ready;
  assign pop       = ~empty & ((DEFER == 1'b0) | blank);
  assign pop_entry = fifo_mem[rd_ptr_q[AW-1:0]];

  // NOTE: every field gets a value on every path, so no latch is inferred.
  always_comb begin
    push_entry.addr = {ptr_q, phase_q == PH_G};
    push_entry.data = (phase_q == PH_G) ? {4'h0, cpu_din[3:0]} : cpu_din;
  end

  // NOTE: storage is deliberately not reset; the pointers alone say which slots are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= push_entry;
    end
  end

  // NOTE: all state updates are non-blocking so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q         <= PH_RB;
      ptr_q           <= 4'h0;
      overflow_q      <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      pwrite_enable_q <= 1'b0;
      pwaddr_q        <= 6'h00;
      pin_q           <= 8'h00;
    end else begin
      if (ptr_wr) begin
        // A pointer write in G abandons the half pair; the queued RB byte stays.
        ptr_q   <= cpu_din[3:0];
        phase_q <= PH_RB;
        if (cpu_din[7]) begin
          overflow_q <= 1'b0;
        end
      end else if (data_wr) begin
        if (cpu_ready) begin
          case (phase_q)
            PH_RB: phase_q <= PH_G;
            PH_G: begin
              phase_q <= PH_RB;
              ptr_q   <= ptr_q + 4'd1;
            end
            default: phase_q <= PH_RB;
          endcase
        end else begin
          overflow_q <= 1'b1;
        end
      end

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end

      if (pop) begin
        rd_ptr_q        <= rd_ptr_q + PTR_ONE;
        pwrite_enable_q <= 1'b1;
        pwaddr_q        <= {1'b0, pop_entry.addr};
        pin_q           <= pop_entry.data;
      end else begin
        pwrite_enable_q <= 1'b0;
      end
    end
  end

  assign pwrite_enable = pwrite_enable_q;
  assign pwaddr        = pwaddr_q;
  assign pin           = pin_q;
  assign ptr           = ptr_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_vdp_palette_port.sv
// Directed bench for vdp_palette_port: an immediate-drain instance (u0) and a
// deferred instance (u1) share all CPU stimulus and the blank input.
module tb_vdp_palette_port;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_wr;
  logic       cpu_port;
  logic [7:0] cpu_din;
  logic       blank;

  logic       rdy0, pwe0, ovf0;
  logic [5:0] addr0;
  logic [7:0] pin0;
  logic [3:0] ptr0;
  logic       rdy1, pwe1, ovf1;
  logic [5:0] addr1;
  logic [7:0] pin1;
  logic [3:0] ptr1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vdp_palette_port #(.FIFO_DEPTH(8), .DEFER(1'b0)) u0 (
    .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_port(cpu_port), .cpu_din(cpu_din),
    .cpu_ready(rdy0), .blank(blank), .pwrite_enable(pwe0), .pwaddr(addr0),
    .pin(pin0), .ptr(ptr0), .overflow(ovf0)
  );

  vdp_palette_port #(.FIFO_DEPTH(8), .DEFER(1'b1)) u1 (
    .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_port(cpu_port), .cpu_din(cpu_din),
    .cpu_ready(rdy1), .blank(blank), .pwrite_enable(pwe1), .pwaddr(addr1),
    .pin(pin1), .ptr(ptr1), .overflow(ovf1)
  );

  typedef struct {
    logic       rst;
    logic       wr;
    logic       port;
    logic [7:0] din;
    logic       pwe;
    logic [5:0] addr;
    logic [7:0] pin;
    logic [3:0] ptr;
    logic       rdy;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } exp_t;

  vec_t vecs[21];
  exp_t exp_q[$];
  logic [3:0] m_ptr;
  logic       m_ph;

  function automatic vec_t mk(input int r, input int w, input int p, input int d,
                              input int pwe, input int a, input int pn, input int pt,
                              input int rdy, input int ovf);
    vec_t v;
    v.rst  = 1'(r);
    v.wr   = 1'(w);
    v.port = 1'(p);
    v.din  = 8'(d);
    v.pwe  = 1'(pwe);
    v.addr = 6'(a);
    v.pin  = 8'(pn);
    v.ptr  = 4'(pt);
    v.rdy  = 1'(rdy);
    v.ovf  = 1'(ovf);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic p, input logic [7:0] d);
    cpu_wr   = w;
    cpu_port = p;
    cpu_din  = d;
  endtask

  task automatic check_outs(input int sel, input string tag, input logic pwe,
                            input logic [5:0] a, input logic [7:0] pn,
                            input logic [3:0] pt, input logic rdy, input logic ovf);
    if (sel == 0) begin
      check({tag, ".u0.pwe"}, int'(pwe0), int'(pwe));
      check({tag, ".u0.pwaddr"}, int'(addr0), int'(a));
      check({tag, ".u0.pin"}, int'(pin0), int'(pn));
      check({tag, ".u0.ptr"}, int'(ptr0), int'(pt));
      check({tag, ".u0.ready"}, int'(rdy0), int'(rdy));
      check({tag, ".u0.overflow"}, int'(ovf0), int'(ovf));
    end else begin
      check({tag, ".u1.pwe"}, int'(pwe1), int'(pwe));
      check({tag, ".u1.pwaddr"}, int'(addr1), int'(a));
      check({tag, ".u1.pin"}, int'(pin1), int'(pn));
      check({tag, ".u1.ptr"}, int'(ptr1), int'(pt));
      check({tag, ".u1.ready"}, int'(rdy1), int'(rdy));
      check({tag, ".u1.overflow"}, int'(ovf1), int'(ovf));
    end
  endtask

  // Independent model of the byte-pair sequencing, used for deferred traffic.
  task automatic data_write(input logic [7:0] d);
    exp_t e;
    e.addr = {1'b0, m_ptr, m_ph};
    e.data = m_ph ? {4'h0, d[3:0]} : d;
    exp_q.push_back(e);
    if (m_ph) m_ptr = m_ptr + 4'd1;
    m_ph = ~m_ph;
    drive(1'b1, 1'b1, d);
  endtask

  task automatic expect_pulse(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, ".queue_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".pwe"}, int'(pwe1), 1);
      check({tag, ".pwaddr"}, int'(addr1), int'(e.addr));
      check({tag, ".pin"}, int'(pin1), int'(e.data));
    end
  endtask

  initial begin
    rst   = 1'b0;
    blank = 1'b1;
    drive(1'b0, 1'b0, 8'h00);

    // Reset, basic pair, wrap/masking and phase abort, all with blank=1.
    vecs[0]  = mk(0, 1, 1, 'hAA, 0,  0,   0,  0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 'h00, 0,  0,   0,  0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 'h05, 0,  0,   0,  0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 'h00, 0,  0,   0,  0, 1, 0);
    vecs[4]  = mk(1, 1, 0, 'h03, 0,  0,   0,  3, 1, 0);
    vecs[5]  = mk(1, 1, 1, 'h52, 0,  0,   0,  3, 1, 0);
    vecs[6]  = mk(1, 1, 1, 'h07, 1,  6, 'h52, 4, 1, 0);
    vecs[7]  = mk(1, 0, 0, 'h00, 1,  7, 'h07, 4, 1, 0);
    vecs[8]  = mk(1, 0, 0, 'h00, 0,  7, 'h07, 4, 1, 0);
    vecs[9]  = mk(1, 1, 0, 'h0F, 0,  7, 'h07, 15, 1, 0);
    vecs[10] = mk(1, 1, 1, 'h77, 0,  7, 'h07, 15, 1, 0);
    vecs[11] = mk(1, 1, 1, 'hA5, 1, 30, 'h77, 0, 1, 0);
    vecs[12] = mk(1, 0, 0, 'h00, 1, 31, 'h05, 0, 1, 0);
    vecs[13] = mk(1, 0, 0, 'h00, 0, 31, 'h05, 0, 1, 0);
    vecs[14] = mk(1, 1, 0, 'h02, 0, 31, 'h05, 2, 1, 0);
    vecs[15] = mk(1, 1, 1, 'h11, 0, 31, 'h05, 2, 1, 0);
    vecs[16] = mk(1, 1, 0, 'h05, 1,  4, 'h11, 5, 1, 0);
    vecs[17] = mk(1, 1, 1, 'h22, 0,  4, 'h11, 5, 1, 0);
    vecs[18] = mk(1, 1, 1, 'h03, 1, 10, 'h22, 6, 1, 0);
    vecs[19] = mk(1, 0, 0, 'h00, 1, 11, 'h03, 6, 1, 0);
    vecs[20] = mk(1, 0, 0, 'h00, 0, 11, 'h03, 6, 1, 0);

    for (int i = 0; i < 21; i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].wr, vecs[i].port, vecs[i].din);
      step();
      check_outs(0, $sformatf("vec%0d", i), vecs[i].pwe, vecs[i].addr, vecs[i].pin,
                 vecs[i].ptr, vecs[i].rdy, vecs[i].ovf);
      check_outs(1, $sformatf("vec%0d", i), vecs[i].pwe, vecs[i].addr, vecs[i].pin,
                 vecs[i].ptr, vecs[i].rdy, vecs[i].ovf);
    end

    // Deferral and overflow on u1: fill with blank low, then overrun by one.
    blank = 1'b0;
    drive(1'b1, 1'b0, 8'h00);
    step();
    check("defer.ptr_set", int'(ptr1), 0);
    m_ptr = 4'h0;
    m_ph  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_write(8'(8'h10 + i));
      step();
      check($sformatf("defer.hold%0d.pwe", i), int'(pwe1), 0);
      if (i == 1) begin
        check("defer.u0_ignores_blank.pwe", int'(pwe0), 1);
        check("defer.u0_ignores_blank.pin", int'(pin0), 'h10);
      end
    end
    check("defer.full.ready", int'(rdy1), 0);
    check("defer.full.ptr", int'(ptr1), 4);
    drive(1'b1, 1'b1, 8'h99);
    step();
    check("defer.drop.overflow", int'(ovf1), 1);
    check("defer.drop.ptr", int'(ptr1), 4);
    check("defer.drop.pwe", int'(pwe1), 0);
    drive(1'b0, 1'b0, 8'h00);
    blank = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_pulse($sformatf("defer.drain%0d", i));
      if (i == 0) check("defer.drain0.ready", int'(rdy1), 1);
    end
    step();
    check("defer.drained.pwe", int'(pwe1), 0);
    drive(1'b1, 1'b0, 8'h80);
    step();
    drive(1'b0, 1'b0, 8'h00);
    check("defer.clear.overflow", int'(ovf1), 0);
    check("defer.clear.ptr", int'(ptr1), 0);

    // Blank interruption: 6 entries, 3 drained, pause, remaining 3.
    blank = 1'b0;
    m_ptr = 4'h0;
    m_ph  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_write(8'(8'h20 + i));
      step();
    end
    drive(1'b0, 1'b0, 8'h00);
    check("blank.queued.pwe", int'(pwe1), 0);
    blank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_pulse($sformatf("blank.first%0d", i));
    end
    blank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("blank.gap%0d.pwe", i), int'(pwe1), 0);
      check($sformatf("blank.gap%0d.pin_hold", i), int'(pin1), 'h22);
    end
    blank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_pulse($sformatf("blank.second%0d", i));
    end
    step();
    check("blank.done.pwe", int'(pwe1), 0);
    check("blank.done.ptr", int'(ptr1), 3);

    // Reset arriving on a drain edge suppresses the pulse and discards the queue.
    blank = 1'b0;
    drive(1'b1, 1'b1, 8'h31);
    step();
    drive(1'b1, 1'b1, 8'h32);
    step();
    drive(1'b0, 1'b0, 8'h00);
    blank = 1'b1;
    rst   = 1'b0;
    step();
    check_outs(1, "rstdrain", 1'b0, 6'd0, 8'h00, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check("rstdrain.after1.pwe", int'(pwe1), 0);
    check("rstdrain.after1.ready", int'(rdy1), 1);
    step();
    check("rstdrain.after2.pwe", int'(pwe1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/vdp_palette_port.md
# vdp_palette_port

CPU-facing palette write port that sits directly upstream of `PaletteRAM` and drives its `pwrite_enable`/`pwaddr`/`pin` inputs. It accepts V9938-style two-byte palette writes: a pointer-port write selects the palette index, then data-port byte pairs are written as R/B then G, with the index auto-incrementing. Accepted bytes are buffered in a small FIFO. With deferral enabled, the FIFO drains only while the video is blanked, so mid-frame colour updates never tear the visible line.

## Interface
- `FIFO_DEPTH`, 8: number of buffered byte writes; must be a power of 2, ≥2.
- `DEFER`, 1: 1 drains only while `blank`=1; 0 drains whenever the FIFO is non-empty.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-low (`rst`=0 resets at the next edge).
- `cpu_wr`  in  1  one-cycle write strobe.
- `cpu_port`  in  1  0 = pointer port, 1 = data port.
- `cpu_din`  in  8  write data.
- `cpu_ready`  out  1  1 = a data-port write is accepted this cycle.
- `blank`  in  1  1 = a PaletteRAM update is permitted (blanking interval).
- `pwrite_enable`  out  1  PaletteRAM write strobe (registered).
- `pwaddr`  out  6  PaletteRAM byte address (registered); bit 5 is always 0.
- `pin`  out  8  PaletteRAM write data (registered).
- `ptr`  out  4  current palette index.
- `overflow`  out  1  sticky flag: a data write was dropped.

## Operation
- **Pointer-port write** (`cpu_wr`=1, `cpu_port`=0):
  - `ptr` <= `cpu_din[3:0]`; `phase` <= 0.
  - If `cpu_din[7]`=1, `overflow` <= 0.
  - Always accepted, independent of `cpu_ready`.
  - Does not affect entries already queued.
- **Data-port write** (`cpu_wr`=1, `cpu_port`=1, `cpu_ready`=1):
  - `phase`=0: enqueue {addr `{ptr,1'b0}`, data `cpu_din`}; `phase` <= 1.
  - `phase`=1: enqueue {addr `{ptr,1'b1}`, data `{4'h0, cpu_din[3:0]}`}; `phase` <= 0; `ptr` <= `ptr`+1 (mod 16, so 15 wraps to 0).
- **Data-port write with `cpu_ready`=0**: dropped; `overflow` <= 1; `ptr`, `phase`, and the FIFO are unchanged.
- `cpu_ready` is combinational: `rst` & (count != `FIFO_DEPTH`), using the registered count. A simultaneous pop does not make a full FIFO ready in the same cycle.
- **FIFO**: entries are 13 bits {addr5, data8}, held in separate read and write pointers one bit wider than log2(`FIFO_DEPTH`). Full and empty are derived from these pointers.
- **Drain condition**: FIFO non-empty and (`DEFER`=0 or `blank`=1), evaluated at each edge. When true, one entry is popped and loaded into `pwaddr`/`pin` with `pwrite_enable` <= 1. Otherwise `pwrite_enable` <= 0, and `pwaddr`/`pin` hold their values.
- **Ordering**: writes reach PaletteRAM in acceptance order, at most one per cycle.
- **Simultaneous push and pop**: both take effect; count is unchanged.
- **Reset**: `ptr`=0, `phase`=0, FIFO emptied (pending entries discarded), `pwrite_enable`=0, `pwaddr`=0, `pin`=0, `overflow`=0. `cpu_ready` is 0 while `rst`=0 and 1 in the first cycle after reset is released. A reset during a drain deasserts `pwrite_enable` at that edge.

## Timing
- **Latency**: with an empty FIFO and the drain condition true, `cpu_wr` high in cycle 0 produces `pwrite_enable` high in cycle 2. PaletteRAM commits the write at the end of cycle 2.
- **Throughput**: one data write accepted per cycle; one PaletteRAM write per cycle.
- **`blank` behaviour**:
  - When `blank` falls, the last pop happens at the last edge where it was sampled 1.
  - `pwrite_enable` is low in the cycle after the first edge that samples 0.
  - Draining resumes on the first edge that samples `blank`=1.
- **State machine**: `phase` ∈ {RB (0), G (1)}.
  - RB→G on an accepted data write.
  - G→RB on an accepted data write, or on any pointer write.
  - A pointer write in G abandons the half pair; the RB byte already queued is still written.

## Test plan
- **Reset**: hold `rst`=0 for 3 cycles with `cpu_wr` toggling. Expect `pwrite_enable`=0, `pwaddr`=0, `pin`=0, `ptr`=0, `overflow`=0, `cpu_ready`=0; after release, `cpu_ready`=1.
- **Basic pair** (`DEFER`=0): pointer write 0x03, then data 0x52 and 0x07 on consecutive cycles. Expect pulses {`pwaddr`=6, `pin`=0x52} then {7, 0x07} in back-to-back cycles, first pulse 2 cycles after the first data strobe; afterwards `ptr`=4.
- **Wrap and masking**: pointer write 0x0F, data 0x77 and 0xA5. Expect writes {30, 0x77} and {31, 0x05}; `ptr`=0.
- **Deferral and overflow** (`DEFER`=1, `blank`=0): 8 data writes, then a 9th. Expect no `pwrite_enable`, `cpu_ready`=0 after the 8th, the 9th dropped, and `overflow`=1. Raising `blank` gives 8 consecutive pulses in acceptance order. Pointer write 0x80 clears `overflow` and sets `ptr`=0.
- **Blank interruption**: queue 6 entries; `blank`=1 for 3 cycles, then 0, then 1. Expect exactly 3 pulses, a gap while `blank`=0, then the remaining 3 in order.
- **Phase abort**: pointer write 2, data 0x11, pointer write 5, data 0x22 and 0x03. Expect writes {4, 0x11}, {10, 0x22}, {11, 0x03}; `ptr`=6.
